register_file_v2: RTL and testbench

//  Parametrised successor to the AVR core register file: DEPTH x DATA_W

---
 rtl/register_file_v2.sv | 157 +++++++++++++++
 tb/tb_register_file_v2.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_v2.sv
// register_file_v2
//   DEPTH x DATA_W register file (DEPTH = 2**ADDR_W) for the AVR-style core.
//   It has one byte write port and one register-pair write port, used by MOVW
//   and ADIW. It has two byte read ports and one pair read port for the X/Y/Z
//   pointers. Write-through bypass is optional. A multi-cycle clear sequencer
//   zeroes one register pair per cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; zeroes the array, idles the clear FSM
//   we         byte write enable (address add1, data din1)
//   we_pair    pair write enable (pair at add1 with bit 0 forced to 0); wins over we
//   add1       byte write / pair write / byte read address
//   add2       byte read address
//   addp       pair read address, bit 0 ignored
//   din1       byte write data
//   din_pair   pair write data {high, low}
//   clr_req    start a runtime clear (ignored while one is running)
//   dout1      reg[add1]
//   dout2      reg[add2]
//   dout_pair  {reg[addp|1], reg[addp&~1]}
//   busy       clear sequence in progress
//   wr_drop    one-cycle pulse after a write was discarded because busy
//   state_dbg  clear FSM state (0 = IDLE, 1 = CLEAR)
//
// Write handshake: there is no back-pressure. A write that is presented while
// busy is low is always accepted at the next rising edge. A write that is
// presented while busy is high is dropped, and wr_drop reports the drop on the
// following cycle.
module register_file_v2 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,   // must be >= 2 so the pair pointer has width
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic                we_pair,
  input  logic [ADDR_W-1:0]   add1,
  input  logic [ADDR_W-1:0]   add2,
  input  logic [ADDR_W-1:0]   addp,
  input  logic [DATA_W-1:0]   din1,
  input  logic [2*DATA_W-1:0] din_pair,
  input  logic                clr_req,
  output logic [DATA_W-1:0]   dout1,
  output logic [DATA_W-1:0]   dout2,
  output logic [2*DATA_W-1:0] dout_pair,
  output logic                busy,
  output logic                wr_drop,
  output logic                state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t              state, state_next;
  logic [ADDR_W-2:0]   ptr, ptr_next;
  logic [DATA_W-1:0]   regs [DEPTH];

  logic                wr_pair_en, wr_byte_en, byp_en;
  logic [ADDR_W-1:0]   pair_lo, pair_hi, rdp_lo, rdp_hi;

  assign busy      = (state == CLEAR);
  assign state_dbg = state;

  // Writes are refused for the whole clear sequence. We loses to we_pair.
  assign wr_pair_en = we_pair & ~busy;
  assign wr_byte_en = we & ~we_pair & ~busy;

  assign pair_lo = {add1[ADDR_W-1:1], 1'b0};
  assign pair_hi = {add1[ADDR_W-1:1], 1'b1};
  assign rdp_lo  = {addp[ADDR_W-1:1], 1'b0};
  assign rdp_hi  = {addp[ADDR_W-1:1], 1'b1};

  // Bypass only forwards a write that will actually land at this edge.
  assign byp_en = (BYPASS != 0) && !reset && !busy;

  // Clear FSM: each CLEAR cycle zeroes one pair. It returns to IDLE after the last pair.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      CLEAR: begin
        ptr_next = ptr + 1'b1;
        if (ptr == {(ADDR_W-1){1'b1}}) begin
          state_next = IDLE;
          ptr_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      wr_drop <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      wr_drop <= busy & (we | we_pair);
      if (busy) begin
        regs[{ptr, 1'b0}] <= '0;
        regs[{ptr, 1'b1}] <= '0;
      end else if (wr_pair_en) begin
        regs[pair_lo] <= din_pair[DATA_W-1:0];
        regs[pair_hi] <= din_pair[2*DATA_W-1:DATA_W];
      end else if (wr_byte_en) begin
        regs[add1] <= din1;
      end
    end
  end

  // Read one byte, forwarding same-cycle write data when bypass is active.
  // A pair write forwards per byte. A byte write forwards only if no pair
  // write is also present, because the pair write suppresses it.
  function automatic logic [DATA_W-1:0] rd_byte(
    input logic [ADDR_W-1:0]   a,
    input logic [DATA_W-1:0]   stored,
    input logic                en,
    input logic                wp,
    input logic                wb,
    input logic [ADDR_W-1:0]   wa,
    input logic [DATA_W-1:0]   wd,
    input logic [2*DATA_W-1:0] wdp
  );
    rd_byte = stored;
    if (en) begin
      if (wp) begin
        if (a[ADDR_W-1:1] == wa[ADDR_W-1:1])
          rd_byte = a[0] ? wdp[2*DATA_W-1:DATA_W] : wdp[DATA_W-1:0];
      end else if (wb && (a == wa)) begin
        rd_byte = wd;
      end
    end
  endfunction

  always_comb begin
    dout1     = rd_byte(add1, regs[add1], byp_en, we_pair, we, add1, din1, din_pair);
    dout2     = rd_byte(add2, regs[add2], byp_en, we_pair, we, add1, din1, din_pair);
    dout_pair = {rd_byte(rdp_hi, regs[rdp_hi], byp_en, we_pair, we, add1, din1, din_pair),
                 rd_byte(rdp_lo, regs[rdp_lo], byp_en, we_pair, we, add1, din1, din_pair)};
  end

endmodule

// File: tb/tb_register_file_v2.sv
// Testbench for register_file_v2. Two instances share every input: one is
// built with BYPASS=1 and one with BYPASS=0. The driver applies one cycle of
// stimulus at a time. For each cycle it pushes the expected outputs into
// exp_q, using a plain array model of the register contents. The monitor pops
// one entry on every falling edge and compares it with both instances.
module tb_register_file_v2;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int NREG = 32;
  // {state, busy, wr_drop, b.dout1, b.dout2, b.dout_pair, n.dout1, n.dout2, n.dout_pair}
  localparam int EW = 3 + 4 * DW + 4 * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, we = 1'b0, we_pair = 1'b0, clr_req = 1'b0;
  logic [AW-1:0] add1 = '0, add2 = '0, addp = '0;
  logic [DW-1:0] din1 = '0;
  logic [2*DW-1:0] din_pair = '0;

  logic [DW-1:0]   b_dout1, b_dout2, n_dout1, n_dout2;
  logic [2*DW-1:0] b_dout_pair, n_dout_pair;
  logic            b_busy, b_wr_drop, b_state, n_busy, n_wr_drop, n_state;

  register_file_v2 #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .we(we), .we_pair(we_pair), .add1(add1), .add2(add2),
    .addp(addp), .din1(din1), .din_pair(din_pair), .clr_req(clr_req),
    .dout1(b_dout1), .dout2(b_dout2), .dout_pair(b_dout_pair), .busy(b_busy),
    .wr_drop(b_wr_drop), .state_dbg(b_state));

  register_file_v2 #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .we(we), .we_pair(we_pair), .add1(add1), .add2(add2),
    .addp(addp), .din1(din1), .din_pair(din_pair), .clr_req(clr_req),
    .dout1(n_dout1), .dout2(n_dout2), .dout_pair(n_dout_pair), .busy(n_busy),
    .wr_drop(n_wr_drop), .state_dbg(n_state));

  // ---------------- reference model ----------------
  logic [DW-1:0] mem [NREG];
  int  clr_left = 0;   // CLEAR cycles still to run
  int  clr_idx  = 0;   // next pair to zero
  bit  drop_m   = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q [$];

  // Expected value of register a, seen through the read port this cycle.
  function automatic logic [DW-1:0] rd_m(input int a, input bit byp);
    if (byp && !reset && clr_left == 0) begin
      if (we_pair) begin
        if (int'(add1) / 2 == a / 2)
          return (a % 2 == 1) ? din_pair[15:8] : din_pair[7:0];
      end else if (we && int'(add1) == a) begin
        return din1;
      end
    end
    return mem[a];
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit chk);
    logic [EW-1:0] e;
    int lo;
    bit busy_m;
    busy_m = (clr_left > 0);
    lo = int'(addp) - (int'(addp) % 2);
    if (chk) begin
      e = {busy_m, busy_m, drop_m,
           rd_m(int'(add1), 1'b1), rd_m(int'(add2), 1'b1), rd_m(lo + 1, 1'b1), rd_m(lo, 1'b1),
           rd_m(int'(add1), 1'b0), rd_m(int'(add2), 1'b0), rd_m(lo + 1, 1'b0), rd_m(lo, 1'b0)};
      exp_q.push_back(e);
    end
    // advance the model across the coming edge
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] = '0;
      clr_left = 0;
      clr_idx  = 0;
      drop_m   = 1'b0;
    end else begin
      drop_m = busy_m && (we || we_pair);
      if (busy_m) begin
        mem[2 * clr_idx]     = '0;
        mem[2 * clr_idx + 1] = '0;
        clr_idx++;
        clr_left--;
      end else begin
        if (clr_req) begin
          clr_left = NREG / 2;
          clr_idx  = 0;
        end
        if (we_pair) begin
          mem[int'(add1) / 2 * 2]     = din_pair[7:0];
          mem[int'(add1) / 2 * 2 + 1] = din_pair[15:8];
        end else if (we) begin
          mem[add1] = din1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; we = 1'b0; we_pair = 1'b0; clr_req = 1'b0;
  endtask

  task automatic sweep_reads();
    for (int i = 0; i < NREG; i++) begin
      idle_inputs();
      add1 = AW'(i); add2 = AW'(NREG - 1 - i); addp = AW'(i);
      step(1'b1);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("state_dbg",   16'(b_state),     16'(e[66]));
      check("busy",        16'(b_busy),      16'(e[65]));
      check("wr_drop",     16'(b_wr_drop),   16'(e[64]));
      check("byp_dout1",   16'(b_dout1),     16'(e[63:56]));
      check("byp_dout2",   16'(b_dout2),     16'(e[55:48]));
      check("byp_pair",    b_dout_pair,      e[47:32]);
      check("nob_dout1",   16'(n_dout1),     16'(e[31:24]));
      check("nob_dout2",   16'(n_dout2),     16'(e[23:16]));
      check("nob_pair",    n_dout_pair,      e[15:0]);
      check("nob_busy",    16'(n_busy),      16'(e[65]));
      check("nob_wr_drop", 16'(n_wr_drop),   16'(e[64]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NREG; i++) mem[i] = '0;
    // Reset: first edge brings the DUT out of X, second is checked.
    reset = 1'b1;
    step(1'b0);
    step(1'b1);

    // 1: all registers read zero after reset
    sweep_reads();

    // 2: write i to reg i, read back through add2 on the next cycle
    for (int i = 0; i <= NREG; i++) begin
      idle_inputs();
      we = (i < NREG); add1 = AW'(i); din1 = DW'(i);
      add2 = AW'((i + NREG - 1) % NREG); addp = AW'(i);
      step(1'b1);
    end

    // 3: same-cycle read of the register being written (A5 vs old 07)
    idle_inputs();
    we = 1'b1; add1 = 5'd7; din1 = 8'hA5; add2 = 5'd7; addp = 5'd6;
    step(1'b1);

    // 4: pair write at odd add1, simultaneous byte write ignored
    idle_inputs();
    we_pair = 1'b1; we = 1'b1; add1 = 5'd27; din_pair = 16'hBEEF; din1 = 8'h55;
    add2 = 5'd26; addp = 5'd26;
    step(1'b1);
    idle_inputs();
    add1 = 5'd26; add2 = 5'd27; addp = 5'd27;
    step(1'b1);

    // 5: runtime clear with a write dropped at clear cycle 3 (reg 2 already cleared)
    idle_inputs();
    clr_req = 1'b1; add1 = 5'd2; add2 = 5'd3; addp = 5'd30;
    step(1'b1);
    for (int c = 1; c <= NREG / 2 + 2; c++) begin
      idle_inputs();
      clr_req = (c == 5);                      // ignored while clearing
      we = (c == 3); add1 = 5'd2; din1 = 8'h77;
      add2 = AW'(2 * (c % 16)); addp = AW'(2 * ((c + 15) % 16));
      step(1'b1);
    end
    sweep_reads();

    // 6: reset in the middle of a clear
    idle_inputs();
    we_pair = 1'b1; add1 = 5'd30; din_pair = 16'h1234;
    step(1'b1);
    idle_inputs();
    clr_req = 1'b1;
    step(1'b1);
    for (int c = 1; c <= 6; c++) begin
      idle_inputs();
      reset = (c == 5); add2 = 5'd31; addp = 5'd30;
      step(1'b1);
    end
    sweep_reads();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      clr_req  = ($urandom_range(0, 39) == 0);
      we       = ($urandom_range(0, 1) == 1);
      we_pair  = ($urandom_range(0, 3) == 0);
      add1     = AW'($urandom_range(0, NREG - 1));
      add2     = ($urandom_range(0, 3) == 0) ? add1 : AW'($urandom_range(0, NREG - 1));
      addp     = ($urandom_range(0, 3) == 0) ? add1 : AW'($urandom_range(0, NREG - 1));
      din1     = DW'($urandom);
      din_pair = 16'($urandom);
      step(1'b1);
    end
    idle_inputs();
    step(1'b1);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
